// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use stall, redirect flush and memory-wait hold control for the RISC-V pipeline
module hazard_control_unit #(
    parameter int NBits_Cnt = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           ID_Rs1_i,
    input  logic [4:0]           ID_Rs2_i,
    input  logic                 ID_Uses_Rs1_i,
    input  logic                 ID_Uses_Rs2_i,
    input  logic                 ID_MemRead_i,
    input  logic [4:0]           ID_Rd_i,
    input  logic                 EX_Redirect_i,
    input  logic                 Mem_Busy_i,
    input  logic                 Count_Clear_i,
    output logic                 Bubble_Sel_o,
    output logic                 PC_Write_o,
    output logic                 IF_ID_Write_o,
    output logic                 IF_ID_Flush_o,
    output logic                 Pipe_Hold_o,
    output logic [NBits_Cnt-1:0] Stall_Cnt_o,
    output logic [NBits_Cnt-1:0] Flush_Cnt_o
);
    typedef enum logic {RUN, REDIRECT_PEND} state_t;
    localparam logic [NBits_Cnt-1:0] ONE = 1;
    state_t               r_state;
    logic                 r_ex_memread;
    logic [4:0]           r_ex_rd;
    logic [NBits_Cnt-1:0] r_stall_cnt;
    logic [NBits_Cnt-1:0] r_flush_cnt;
    logic                 w_load_use;
    logic                 w_redirect;
    logic                 w_stall;
    assign w_load_use = r_ex_memread && r_ex_rd != 5'd0 &&
                        ((ID_Uses_Rs1_i && ID_Rs1_i == r_ex_rd) || (ID_Uses_Rs2_i && ID_Rs2_i == r_ex_rd));
    // A pending redirect fires on the first non-busy cycle whatever EX shows then
    assign w_redirect = !Mem_Busy_i && (r_state == REDIRECT_PEND || EX_Redirect_i);
    assign w_stall    = !Mem_Busy_i && r_state == RUN && !EX_Redirect_i && w_load_use;
    assign Bubble_Sel_o  = reset || w_redirect || w_stall;
    assign IF_ID_Flush_o = reset || w_redirect;
    assign PC_Write_o    = !reset && !Mem_Busy_i && !w_stall;
    assign IF_ID_Write_o = PC_Write_o;
    assign Pipe_Hold_o   = !reset && Mem_Busy_i;
    assign Stall_Cnt_o   = r_stall_cnt;
    assign Flush_Cnt_o   = r_flush_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= RUN;
            r_ex_memread <= 1'b0;
            r_ex_rd      <= 5'd0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else begin
            r_state <= Mem_Busy_i ? ((r_state == RUN && EX_Redirect_i) ? REDIRECT_PEND : r_state) : RUN;
            if (!Mem_Busy_i) begin
                r_ex_memread <= ID_MemRead_i && !Bubble_Sel_o;
                r_ex_rd      <= Bubble_Sel_o ? 5'd0 : ID_Rd_i;
            end
            r_stall_cnt <= Count_Clear_i ? '0 : (w_stall && ~&r_stall_cnt) ? r_stall_cnt + ONE : r_stall_cnt;
            r_flush_cnt <= Count_Clear_i ? '0 : (w_redirect && ~&r_flush_cnt) ? r_flush_cnt + ONE : r_flush_cnt;
        end
    end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed checks of stall, flush, hold, counter and reset behaviour
module tb_hazard_control_unit;
    localparam int CW = 8;
    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    ID_Rs1_i, ID_Rs2_i, ID_Rd_i;
    logic          ID_Uses_Rs1_i, ID_Uses_Rs2_i, ID_MemRead_i;
    logic          EX_Redirect_i, Mem_Busy_i, Count_Clear_i;
    logic          Bubble_Sel_o, PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, Pipe_Hold_o;
    logic [CW-1:0] Stall_Cnt_o, Flush_Cnt_o;
    int            total = 0;
    int            bad = 0;
    logic [4:0]    w_out;

    hazard_control_unit #(.NBits_Cnt(CW)) dut (
        .clk(clk), .reset(reset),
        .ID_Rs1_i(ID_Rs1_i), .ID_Rs2_i(ID_Rs2_i),
        .ID_Uses_Rs1_i(ID_Uses_Rs1_i), .ID_Uses_Rs2_i(ID_Uses_Rs2_i),
        .ID_MemRead_i(ID_MemRead_i), .ID_Rd_i(ID_Rd_i),
        .EX_Redirect_i(EX_Redirect_i), .Mem_Busy_i(Mem_Busy_i), .Count_Clear_i(Count_Clear_i),
        .Bubble_Sel_o(Bubble_Sel_o), .PC_Write_o(PC_Write_o), .IF_ID_Write_o(IF_ID_Write_o),
        .IF_ID_Flush_o(IF_ID_Flush_o), .Pipe_Hold_o(Pipe_Hold_o),
        .Stall_Cnt_o(Stall_Cnt_o), .Flush_Cnt_o(Flush_Cnt_o)
    );

    always #5 clk = ~clk;
    // {bubble, flush, pc_write, if_id_write, hold}
    assign w_out = {Bubble_Sel_o, IF_ID_Flush_o, PC_Write_o, IF_ID_Write_o, Pipe_Hold_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ID_Rs1_i = 0; ID_Rs2_i = 0; ID_Rd_i = 0;
        ID_Uses_Rs1_i = 0; ID_Uses_Rs2_i = 0; ID_MemRead_i = 0;
        EX_Redirect_i = 0; Mem_Busy_i = 0; Count_Clear_i = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] rd);
        idle();
        ID_MemRead_i = 1; ID_Rd_i = rd;
    endtask

    task automatic reader(input logic [4:0] rs);
        idle();
        ID_Uses_Rs1_i = 1; ID_Rs1_i = rs; ID_Rd_i = 5'd10;
    endtask

    initial begin
        idle();
        reset = 1;
        #2;
        check("reset_outs", 32'(w_out), 32'b11000);
        check("reset_stall_cnt", 32'(Stall_Cnt_o), 0);
        check("reset_flush_cnt", 32'(Flush_Cnt_o), 0);
        cyc();
        reset = 0;
        #1;
        check("first_run_advance", 32'(w_out), 32'b00110);
        // load x5 then reader of x5
        cyc(); load(5'd5); #1;
        check("load_advance", 32'(w_out), 32'b00110);
        cyc(); reader(5'd5); #1;
        check("load_use_bubble", 32'(w_out), 32'b10000);
        cyc(); #1;
        check("load_use_release", 32'(w_out), 32'b00110);
        check("stall_cnt_one", 32'(Stall_Cnt_o), 1);
        // clear, then x0 load must not stall
        cyc(); idle(); Count_Clear_i = 1; #1;
        cyc(); load(5'd0); #1;
        check("clear_stall_cnt", 32'(Stall_Cnt_o), 0);
        cyc(); reader(5'd0); #1;
        check("x0_no_stall", 32'(w_out), 32'b00110);
        cyc(); #1;
        check("x0_stall_cnt", 32'(Stall_Cnt_o), 0);
        // redirect beats load-use, via rs2
        load(5'd7); #1;
        cyc(); idle(); ID_Uses_Rs2_i = 1; ID_Rs2_i = 5'd7; EX_Redirect_i = 1; #1;
        check("redirect_over_load_use", 32'(w_out), 32'b11110);
        cyc(); EX_Redirect_i = 0; #1;
        check("after_redirect_shadow_clear", 32'(w_out), 32'b00110);
        check("redirect_flush_cnt", 32'(Flush_Cnt_o), 1);
        check("redirect_stall_cnt", 32'(Stall_Cnt_o), 0);
        // redirect pulses during a three-cycle memory wait
        cyc(); idle(); Mem_Busy_i = 1; EX_Redirect_i = 1; #1;
        check("busy1", 32'(w_out), 32'b00001);
        cyc(); #1;
        check("busy2_repeat_pulse", 32'(w_out), 32'b00001);
        cyc(); EX_Redirect_i = 0; #1;
        check("busy3", 32'(w_out), 32'b00001);
        cyc(); Mem_Busy_i = 0; #1;
        check("deferred_flush", 32'(w_out), 32'b11110);
        cyc(); #1;
        check("after_deferred_flush", 32'(w_out), 32'b00110);
        check("deferred_flush_cnt", 32'(Flush_Cnt_o), 2);
        // shadow holds across a busy cycle
        load(5'd9); #1;
        cyc(); reader(5'd9); Mem_Busy_i = 1; #1;
        check("busy_masks_stall", 32'(w_out), 32'b00001);
        cyc(); Mem_Busy_i = 0; #1;
        check("stall_after_busy", 32'(w_out), 32'b10000);
        // saturate the stall counter
        cyc(); idle(); Count_Clear_i = 1; #1;
        for (int i = 0; i < (1 << CW) - 1; i++) begin
            cyc(); load(5'd3); #1;
            cyc(); reader(5'd3); #1;
        end
        cyc(); idle(); #1;
        check("stall_cnt_full", 32'(Stall_Cnt_o), (1 << CW) - 1);
        check("flush_cnt_cleared", 32'(Flush_Cnt_o), 0);
        load(5'd3); #1;
        cyc(); reader(5'd3); #1;
        check("sat_stall_bubble", 32'(w_out), 32'b10000);
        cyc(); idle(); #1;
        check("stall_cnt_saturated", 32'(Stall_Cnt_o), (1 << CW) - 1);
        load(5'd3); #1;
        cyc(); reader(5'd3); Count_Clear_i = 1; #1;
        check("clear_during_stall_bubble", 32'(w_out), 32'b10000);
        cyc(); idle(); #1;
        check("clear_during_stall_cnt", 32'(Stall_Cnt_o), 0);
        // reset while a redirect is pending during busy
        Mem_Busy_i = 1; EX_Redirect_i = 1; #1;
        cyc(); EX_Redirect_i = 0; #1;
        check("pend_hold", 32'(w_out), 32'b00001);
        reset = 1; #1;
        check("reset_mid_pend", 32'(w_out), 32'b11000);
        check("reset_mid_pend_flush_cnt", 32'(Flush_Cnt_o), 0);
        cyc(); reset = 0; Mem_Busy_i = 0; #1;
        check("no_flush_after_reset", 32'(w_out), 32'b00110);
        cyc(); #1;
        check("flush_cnt_after_reset", 32'(Flush_Cnt_o), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
